prbs16_checker: RTL and testbench

Serial PRBS checker that consumes the one-bit stream of the 16-bit Fibonacci LFSR generator, polynomial x^16 + x^14 + x^13 + x^11 + 1. It sits directly downstream of the generator, possibly across a link or DUT. It self-synchronises to the stream, declares lock, and counts bit errors once locked. It flywheels on its own reference sequence so that a single corrupted bit is counted exactly once.

---
 rtl/prbs16_checker_if.sv | 22 ++
 rtl/prbs16_checker.sv | 130 +++++++++++++
 tb/tb_prbs16_checker.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/prbs16_checker_if.sv
// Serial-bit bus between a PRBS16 source and the checker.
// The checker drives the lock and error-status signals back to the source side.
interface prbs16_checker_if #(
  parameter int ERR_W = 16
);
  logic             i_en;
  logic             i_din;
  logic             i_clr_cnt;
  logic             o_locked;
  logic             o_err_pulse;
  logic [ERR_W-1:0] o_err_cnt;

  modport master (
    output i_en, i_din, i_clr_cnt,
    input  o_locked, o_err_pulse, o_err_cnt
  );

  modport slave (
    input  i_en, i_din, i_clr_cnt,
    output o_locked, o_err_pulse, o_err_cnt
  );
endinterface

// File: rtl/prbs16_checker.sv
// Self-synchronising checker for the x^16+x^14+x^13+x^11+1 PRBS stream.
// After lock it flywheels on its own sequence, so each corrupted bit counts once.
module prbs16_checker #(
  parameter int LOCK_CNT = 32,
  parameter int LOSS_CNT = 8,
  parameter int ERR_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  prbs16_checker_if.slave  bus
);
  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int LW = $clog2(LOSS_CNT + 1);

  localparam logic [MW-1:0]    MATCH_ONE  = MW'(1);
  localparam logic [MW-1:0]    MATCH_LAST = MW'(LOCK_CNT - 1);
  localparam logic [LW-1:0]    MISS_ONE   = LW'(1);
  localparam logic [LW-1:0]    MISS_LAST  = LW'(LOSS_CNT - 1);
  localparam logic [ERR_W-1:0] ERR_ONE    = ERR_W'(1);

  typedef enum logic [1:0] {
    SEED   = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  function automatic logic prbs_fb(input logic [15:0] h);
    return h[15] ^ h[13] ^ h[12] ^ h[10];
  endfunction

  state_t           r_state;
  logic [15:0]      r_h;
  logic [3:0]       r_seed_cnt;
  logic [MW-1:0]    r_match_cnt;
  logic [5:0]       r_win_cnt;
  logic [LW-1:0]    r_miss_cnt;
  logic [ERR_W-1:0] r_err_cnt;
  logic             r_err_pulse;
  logic             r_locked;

  logic             w_exp;
  logic             w_mismatch;
  logic [15:0]      w_h_din;
  logic [15:0]      w_h_exp;
  logic             w_count_err;

  assign w_exp       = prbs_fb(r_h);
  assign w_mismatch  = bus.i_en & (bus.i_din != w_exp);
  assign w_h_din     = {r_h[14:0], bus.i_din};
  assign w_h_exp     = {r_h[14:0], w_exp};
  assign w_count_err = (r_state == LOCKED) & w_mismatch & ~(&r_err_cnt);

  // Sync FSM, history register, window/miss counters and error statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= SEED;
      r_h         <= 16'd0;
      r_seed_cnt  <= 4'd0;
      r_match_cnt <= '0;
      r_win_cnt   <= 6'd0;
      r_miss_cnt  <= '0;
      r_err_cnt   <= '0;
      r_err_pulse <= 1'b0;
      r_locked    <= 1'b0;
    end else begin
      r_err_pulse <= 1'b0;
      // Clear beats a coincident increment.
      if (bus.i_clr_cnt) begin
        r_err_cnt <= '0;
      end else if (w_count_err) begin
        r_err_cnt <= r_err_cnt + ERR_ONE;
      end

      if (bus.i_en) begin
        case (r_state)
          SEED: begin
            r_h <= w_h_din;
            if (r_seed_cnt == 4'd15) begin
              r_seed_cnt <= 4'd0;
              // All-zero history would self-predict zeros forever; reseed instead.
              if (w_h_din != 16'd0) begin
                r_state     <= TRACK;
                r_match_cnt <= '0;
              end
            end else begin
              r_seed_cnt <= r_seed_cnt + 4'd1;
            end
          end
          TRACK: begin
            r_h <= w_h_din;
            if (w_mismatch) begin
              r_state    <= SEED;
              r_seed_cnt <= 4'd1;
            end else if (r_match_cnt == MATCH_LAST) begin
              r_state    <= LOCKED;
              r_locked   <= 1'b1;
              r_win_cnt  <= 6'd0;
              r_miss_cnt <= '0;
            end else begin
              r_match_cnt <= r_match_cnt + MATCH_ONE;
            end
          end
          LOCKED: begin
            r_h         <= w_h_exp;
            r_err_pulse <= w_mismatch;
            r_win_cnt   <= r_win_cnt + 6'd1;
            if (w_mismatch && (r_miss_cnt == MISS_LAST)) begin
              r_state    <= SEED;
              r_seed_cnt <= 4'd0;
              r_locked   <= 1'b0;
            end else if (r_win_cnt == 6'd63) begin
              r_miss_cnt <= w_mismatch ? MISS_ONE : '0;
            end else if (w_mismatch) begin
              r_miss_cnt <= r_miss_cnt + MISS_ONE;
            end
          end
          default: begin
            r_state    <= SEED;
            r_seed_cnt <= 4'd0;
            r_locked   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.o_locked    = r_locked;
  assign bus.o_err_pulse = r_err_pulse;
  assign bus.o_err_cnt   = r_err_cnt;
endmodule

// File: tb/tb_prbs16_checker.sv
// Directed bench for prbs16_checker: lock, single error, loss/relock, stuck-at-0,
// gapped input, saturation, clear priority and asynchronous reset.
module tb_prbs16_checker;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic din = 1'b0;
  logic clr = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  bit prbs [0:10047];

  always #5 clk = ~clk;

  prbs16_checker_if #(.ERR_W(16)) bus16 ();
  prbs16_checker_if #(.ERR_W(4))  bus4 ();

  assign bus16.i_en = en;
  assign bus16.i_din = din;
  assign bus16.i_clr_cnt = clr;
  assign bus4.i_en = en;
  assign bus4.i_din = din;
  assign bus4.i_clr_cnt = clr;

  prbs16_checker #(.LOCK_CNT(32), .LOSS_CNT(8), .ERR_W(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .bus(bus16.slave)
  );
  prbs16_checker #(.LOCK_CNT(32), .LOSS_CNT(8), .ERR_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic e, input logic d, input logic c);
    @(negedge clk);
    en = e;
    din = d;
    clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    en = 1'b0;
    din = 1'b0;
    clr = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int pulses;
    int locks;
    logic inv;

    for (int i = 0; i < 10048; i++) begin
      if (i < 15) prbs[i] = 1'b0;
      else if (i == 15) prbs[i] = 1'b1;
      else prbs[i] = prbs[i-16] ^ prbs[i-14] ^ prbs[i-13] ^ prbs[i-11];
    end

    #12;
    check("rst_locked", {31'd0, bus16.o_locked}, 32'd0);
    check("rst_pulse", {31'd0, bus16.o_err_pulse}, 32'd0);
    check("rst_cnt", {16'd0, bus16.o_err_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Error-free lock over 10000 bits.
    pulses = 0;
    for (int i = 0; i < 10000; i++) begin
      send(1'b1, prbs[i], 1'b0);
      if (bus16.o_err_pulse) pulses++;
      if (i == 46) check("a_lock_46", {31'd0, bus16.o_locked}, 32'd0);
      if (i == 47) check("a_lock_47", {31'd0, bus16.o_locked}, 32'd1);
    end
    check("a_pulses", pulses, 32'd0);
    check("a_cnt", {16'd0, bus16.o_err_cnt}, 32'd0);
    check("a_locked_end", {31'd0, bus16.o_locked}, 32'd1);

    // Single inverted bit at index 1000.
    do_reset();
    pulses = 0;
    for (int i = 0; i < 3000; i++) begin
      send(1'b1, prbs[i] ^ (i == 1000), 1'b0);
      if (bus16.o_err_pulse) pulses++;
      if (i == 999) check("b_pulse_999", {31'd0, bus16.o_err_pulse}, 32'd0);
      if (i == 1000) check("b_pulse_1000", {31'd0, bus16.o_err_pulse}, 32'd1);
      if (i == 1001) check("b_pulse_1001", {31'd0, bus16.o_err_pulse}, 32'd0);
    end
    check("b_pulses", pulses, 32'd1);
    check("b_cnt", {16'd0, bus16.o_err_cnt}, 32'd1);
    check("b_locked", {31'd0, bus16.o_locked}, 32'd1);

    // Burst 200..207 in window 176..239 drops lock; relock after 16 seed + 32 match.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      send(1'b1, prbs[i] ^ (i >= 200 && i <= 207), 1'b0);
      if (i == 206) check("c_lock_206", {31'd0, bus16.o_locked}, 32'd1);
      if (i == 207) check("c_lock_207", {31'd0, bus16.o_locked}, 32'd0);
      if (i == 254) check("c_lock_254", {31'd0, bus16.o_locked}, 32'd0);
      if (i == 255) check("c_lock_255", {31'd0, bus16.o_locked}, 32'd1);
    end
    check("c_cnt", {16'd0, bus16.o_err_cnt}, 32'd8);

    // Stuck-at-0 for 200 bits, then the generator stream from its reset state.
    do_reset();
    locks = 0;
    for (int i = 0; i < 200; i++) begin
      send(1'b1, 1'b0, 1'b0);
      if (bus16.o_locked) locks++;
    end
    check("d_no_lock", locks, 32'd0);
    check("d_cnt", {16'd0, bus16.o_err_cnt}, 32'd0);
    // 200 zeros leave the seed counter at 8, so the 16-bit seed windows end at
    // stream bits 7 (all-zero, reseed) and 23; lock follows at stream bit 55.
    for (int j = 0; j < 100; j++) begin
      send(1'b1, prbs[j], 1'b0);
      if (j == 47) check("d_lock_47", {31'd0, bus16.o_locked}, 32'd0);
      if (j == 54) check("d_lock_54", {31'd0, bus16.o_locked}, 32'd0);
      if (j == 55) check("d_lock_55", {31'd0, bus16.o_locked}, 32'd1);
    end

    // Gapped input: one valid bit in three, error at index 80.
    do_reset();
    for (int i = 0; i < 100; i++) begin
      send(1'b1, prbs[i] ^ (i == 80), 1'b0);
      if (i == 46) check("e_lock_46", {31'd0, bus16.o_locked}, 32'd0);
      if (i == 47) check("e_lock_47", {31'd0, bus16.o_locked}, 32'd1);
      if (i == 80) check("e_pulse_80", {31'd0, bus16.o_err_pulse}, 32'd1);
      send(1'b0, 1'b0, 1'b0);
      if (i == 80) begin
        check("e_pulse_idle", {31'd0, bus16.o_err_pulse}, 32'd0);
        check("e_cnt_idle", {16'd0, bus16.o_err_cnt}, 32'd1);
      end
      send(1'b0, 1'b1, 1'b0);
    end
    check("e_locked_end", {31'd0, bus16.o_locked}, 32'd1);

    // Saturation (4-bit counter), clear priority and async reset mid-lock.
    do_reset();
    for (int i = 0; i < 1600; i++) begin
      inv = ((i >= 100) && (i <= 1316) && (((i - 100) % 64) == 0)) || (i == 1400) || (i == 1500);
      send(1'b1, prbs[i] ^ inv, (i == 1400));
      if (i == 932) check("f_cnt4_14", {28'd0, bus4.o_err_cnt}, 32'd14);
      if (i == 1316) begin
        check("f_cnt4_sat", {28'd0, bus4.o_err_cnt}, 32'd15);
        check("f_cnt16_20", {16'd0, bus16.o_err_cnt}, 32'd20);
        check("f_lock4", {31'd0, bus4.o_locked}, 32'd1);
      end
      if (i == 1400) begin
        check("f_clr16", {16'd0, bus16.o_err_cnt}, 32'd0);
        check("f_clr4", {28'd0, bus4.o_err_cnt}, 32'd0);
        check("f_clr_pulse", {31'd0, bus16.o_err_pulse}, 32'd1);
      end
      if (i == 1500) begin
        check("f_cnt_after_clr", {16'd0, bus16.o_err_cnt}, 32'd1);
        check("f_pulse_1500", {31'd0, bus16.o_err_pulse}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("g_rst_locked", {31'd0, bus16.o_locked}, 32'd0);
        check("g_rst_pulse", {31'd0, bus16.o_err_pulse}, 32'd0);
        check("g_rst_cnt", {16'd0, bus16.o_err_cnt}, 32'd0);
        break;
      end
    end
    @(negedge clk);
    en = 1'b0;
    rst_n = 1'b1;
    send(1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
